shift_sequencer: RTL and testbench

- Multi-cycle controller that owns the 32-bit accumulator and sequences one barrel shifter and one parallel shifter.
- Executes four shift-class commands against 16-bit data RAM: load accumulator, add to accumulator, subtract from accumulator, and store accumulator high.
- Sits between the instruction decoder (valid/ready command port) and data RAM.
- Drives the shifters' data/shift inputs and consumes their outputs; the shifters themselves are instantiated alongside it.

---
 rtl/shift_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_shift_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle accumulator controller sequencing an external barrel shifter and parallel shifter
// against 16-bit data RAM. Optional build macro SHIFT_SAT_EN saturates acc on ADD/SUB overflow.
`timescale 1ns/1ps

module shift_sequencer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [3:0]    cmd_sh,
  output logic          done,
  output logic [31:0]   acc,
  output logic          ov,
  input  logic          ov_clr,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  input  logic [15:0]   dm_rdata,
  output logic          dm_wr,
  output logic [15:0]   dm_wdata,
  output logic [15:0]   bsh_in,
  output logic [3:0]    bsh_sh,
  input  logic [31:0]   bsh_out,
  output logic [31:0]   par_in,
  output logic [3:0]    par_sh,
  input  logic [15:0]   par_out
);

  localparam logic [1:0] OP_LAC  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_SACH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_op;
  logic [AW-1:0]        r_addr;
  logic [3:0]           r_sh;
  logic                 r_done;
  logic signed [31:0]   r_acc;
  logic                 r_ov;

  logic [15:0]          r_bsh_in;
  logic [3:0]           r_bsh_sh;
  logic [31:0]          r_par_in;
  logic [3:0]           r_par_sh;

  logic                 w_accept;
  logic signed [31:0]   w_opnd;
  logic signed [31:0]   w_sum;
  logic signed [31:0]   w_diff;
  logic signed [31:0]   w_wrap;
  logic signed [31:0]   w_acc_nxt;
  logic                 w_ovf;

  // Overflow of a two's complement add/sub: result sign departs from acc sign
  // when the effective operand signs agree.
  function automatic logic ovf_detect(input logic a_sign, input logic b_sign,
                                      input logic r_sign, input logic is_sub);
    logic same_eff;
    same_eff = is_sub ? (a_sign != b_sign) : (a_sign == b_sign);
    return same_eff && (r_sign != a_sign);
  endfunction

  function automatic logic signed [31:0] sat_limit(input logic neg);
    return neg ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  endfunction

  assign w_accept = cmd_valid & cmd_ready;
  assign w_opnd   = bsh_out;
  assign w_sum    = r_acc + w_opnd;
  assign w_diff   = r_acc - w_opnd;

  always_comb begin
    w_ovf  = 1'b0;
    w_wrap = r_acc;
    case (r_op)
      OP_LAC: w_wrap = w_opnd;
      OP_ADD: begin
        w_wrap = w_sum;
        w_ovf  = ovf_detect(r_acc[31], w_opnd[31], w_sum[31], 1'b0);
      end
      OP_SUB: begin
        w_wrap = w_diff;
        w_ovf  = ovf_detect(r_acc[31], w_opnd[31], w_diff[31], 1'b1);
      end
      default: w_wrap = r_acc;
    endcase
    w_acc_nxt = w_wrap;
`ifdef SHIFT_SAT_EN
    // Overflow direction always follows the sign of the accumulator before the op.
    if (w_ovf) w_acc_nxt = sat_limit(r_acc[31]);
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    dm_rd       = 1'b0;
    dm_wr       = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    bsh_in      = r_bsh_in;
    bsh_sh      = r_bsh_sh;
    par_in      = r_par_in;
    par_sh      = r_par_sh;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = (cmd_op == OP_SACH) ? WRITE : READ;
      end
      READ: begin
        dm_rd       = 1'b1;
        dm_addr     = r_addr;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        bsh_in      = dm_rdata;
        bsh_sh      = r_sh;
        w_state_nxt = IDLE;
      end
      WRITE: begin
        par_in      = r_acc;
        par_sh      = r_sh;
        dm_wr       = 1'b1;
        dm_addr     = r_addr;
        dm_wdata    = par_out;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state: reset applies here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_acc   <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == EXEC) || (r_state == WRITE);
      if (r_state == EXEC) r_acc <= w_acc_nxt;
      if ((r_state == EXEC) && w_ovf) r_ov <= 1'b1;
      else if (ov_clr)                r_ov <= 1'b0;
    end
  end

  // Command latch and shifter input holds: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op   <= cmd_op;
      r_addr <= cmd_addr;
      r_sh   <= cmd_sh;
    end
    if (r_state == EXEC) begin
      r_bsh_in <= dm_rdata;
      r_bsh_sh <= r_sh;
    end
    if (r_state == WRITE) begin
      r_par_in <= r_acc;
      r_par_sh <= r_sh;
    end
  end

  assign done = r_done;
  assign acc  = r_acc;
  assign ov   = r_ov;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed scenarios plus randomized commands checked
// against an arithmetic reference model; shifters and RAM are modelled here.
`timescale 1ns/1ps

module tb_shift_sequencer;

  localparam int AW = 8;
  localparam logic [1:0] LAC = 2'b00, ADD = 2'b01, SUB = 2'b10, SACH = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_sh;
  logic          done;
  logic [31:0]   acc;
  logic          ov;
  logic          ov_clr;
  logic [AW-1:0] dm_addr;
  logic          dm_rd;
  logic [15:0]   dm_rdata;
  logic          dm_wr;
  logic [15:0]   dm_wdata;
  logic [15:0]   bsh_in;
  logic [3:0]    bsh_sh;
  logic [31:0]   bsh_out;
  logic [31:0]   par_in;
  logic [3:0]    par_sh;
  logic [15:0]   par_out;
  logic [31:0]   par_full;

  always #5 clk = ~clk;

  shift_sequencer #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_sh(cmd_sh), .done(done),
    .acc(acc), .ov(ov), .ov_clr(ov_clr), .dm_addr(dm_addr), .dm_rd(dm_rd),
    .dm_rdata(dm_rdata), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
    .bsh_in(bsh_in), .bsh_sh(bsh_sh), .bsh_out(bsh_out),
    .par_in(par_in), .par_sh(par_sh), .par_out(par_out)
  );

  // Shifter and RAM environment
  assign bsh_out  = {{16{bsh_in[15]}}, bsh_in} << bsh_sh;
  assign par_full = par_in << par_sh;
  assign par_out  = par_full[31:16];

  logic [15:0]   mem [256];
  logic          bd_we = 1'b0;
  logic [7:0]    bd_addr = '0;
  logic [15:0]   bd_data = '0;
  always @(posedge clk) begin
    if (dm_rd) dm_rdata <= mem[dm_addr];
    if (dm_wr) mem[dm_addr] <= dm_wdata;
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    int          a_cyc;
    int          done_cyc;
    logic [31:0] acc;
    logic        ov;
    logic [15:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] ref_mem [256];
  logic [31:0] ref_acc = '0;
  logic        ref_ov  = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: plain signed arithmetic on 64-bit integers.
  task automatic model(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] sh,
                       input bit clr, inout exp_t e);
    longint a, b, s;
    logic [63:0] t;
    if (clr) ref_ov = 1'b0;
    a = longint'($signed(ref_acc));
    b = longint'($signed(ref_mem[addr])) * (longint'(1) << sh);
    e.wdata = '0;
    case (op)
      LAC: ref_acc = b[31:0];
      ADD, SUB: begin
        s = (op == ADD) ? a + b : a - b;
        if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
          ref_ov = 1'b1;
`ifdef SHIFT_SAT_EN
          s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
        end
        ref_acc = s[31:0];
      end
      default: begin
        t = {32'd0, ref_acc} << sh;
        e.wdata = t[31:16];
        ref_mem[addr] = t[31:16];
      end
    endcase
    e.acc = ref_acc;
    e.ov  = ref_ov;
  endtask

  task automatic setmem(input logic [7:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Presents a command and returns right after the accepting edge, cmd_valid still high.
  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] sh,
                       input bit clr, input bit hold, output int acc_cyc);
    exp_t e;
    int n = 0;
    acc_cyc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_sh = sh;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      flag("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    ov_clr = clr;
    @(posedge clk); #1;
    acc_cyc = cyc;
    e.op = op; e.addr = addr; e.a_cyc = cyc;
    e.done_cyc = cyc + ((op == SACH) ? 1 : 2);
    model(op, addr, sh, clr, e);
    sbq.push_back(e);
    if (!hold) ov_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      flag("idle_timeout");
      sbq.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] sh,
                     input bit clr, input bit hold);
    int a;
    int n = 0;
    issue(op, addr, sh, clr, hold, a);
    cmd_valid = 1'b0;
    if (hold) begin
      while (!done && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      ov_clr = 1'b0;
    end
    wait_idle();
  endtask

  task automatic build_max();
    setmem(8'h01, 16'h7FFF);
    setmem(8'h02, 16'h0001);
    run(LAC, 8'h01, 4'd15, 1'b1, 1'b0);
    run(ADD, 8'h01, 4'd15, 1'b0, 1'b0);
    run(ADD, 8'h01, 4'd0,  1'b0, 1'b0);
    run(ADD, 8'h01, 4'd0,  1'b0, 1'b0);
    run(ADD, 8'h02, 4'd0,  1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads, writes or retires.
  initial begin
    bit exp_ready;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dm_rd && dm_wr) flag("rd_wr_overlap");
        exp_ready = (sbq.size() == 0) || (sbq[0].done_cyc == cyc);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        if (dm_rd) begin
          if (sbq.size() == 0 || sbq[0].op == SACH) flag("unexpected_dm_rd");
          else begin
            chk("rd_cycle", 32'(cyc), 32'(sbq[0].a_cyc));
            chk("rd_addr", 32'(dm_addr), 32'(sbq[0].addr));
          end
        end
        if (dm_wr) begin
          if (sbq.size() == 0 || sbq[0].op != SACH) flag("unexpected_dm_wr");
          else begin
            chk("wr_cycle", 32'(cyc), 32'(sbq[0].a_cyc));
            chk("wr_addr", 32'(dm_addr), 32'(sbq[0].addr));
            chk("wr_data", 32'(dm_wdata), 32'(sbq[0].wdata));
          end
        end
        if (done) begin
          if (sbq.size() == 0) flag("spurious_done");
          else begin
            chk("done_cycle", 32'(cyc), 32'(sbq[0].done_cyc));
            chk("acc", acc, sbq[0].acc);
            chk("ov", 32'(ov), 32'(sbq[0].ov));
            void'(sbq.pop_front());
          end
        end else if (sbq.size() != 0 && cyc > sbq[0].done_cyc) begin
          flag("missing_done");
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    logic [15:0] rv;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_sh = '0; ov_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rv = 16'($urandom);
      setmem(8'(i), rv);
    end
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_acc", acc, 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dm_rd", 32'(dm_rd), 32'd0);
    chk("rst_dm_wr", 32'(dm_wr), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_wdata", 32'(dm_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // LAC with sign extension
    setmem(8'h05, 16'h8001);
    run(LAC, 8'h05, 4'd4, 1'b0, 1'b0);
    chk("lac_acc", acc, 32'hFFF8_0010);
    chk("lac_ov", 32'(ov), 32'd0);

    // ADD overflow at the positive limit
    build_max();
    chk("max_acc", acc, 32'h7FFF_FFFF);
    run(ADD, 8'h02, 4'd0, 1'b0, 1'b0);
`ifdef SHIFT_SAT_EN
    chk("addovf_acc", acc, 32'h7FFF_FFFF);
`else
    chk("addovf_acc", acc, 32'h8000_0000);
`endif
    chk("addovf_ov", 32'(ov), 32'd1);
    ov_clr = 1'b1; ref_ov = 1'b0;
    @(posedge clk); #1;
    ov_clr = 1'b0;
    chk("ov_clr", 32'(ov), 32'd0);

    // ov_clr held across an overflowing ADD: set must win
    build_max();
    run(ADD, 8'h02, 4'd0, 1'b1, 1'b1);
    chk("setwins_ov", 32'(ov), 32'd1);

    // SUB to zero, then below zero
    setmem(8'h03, 16'h0001);
    run(LAC, 8'h03, 4'd8, 1'b1, 1'b0);
    run(SUB, 8'h03, 4'd8, 1'b0, 1'b0);
    chk("sub_zero", acc, 32'h0000_0000);
    chk("sub_ov", 32'(ov), 32'd0);
    run(SUB, 8'h03, 4'd0, 1'b0, 1'b0);
    chk("sub_neg", acc, 32'hFFFF_FFFF);

    // SACH of 0x00012345 << 4
    setmem(8'h04, 16'h1234);
    setmem(8'h06, 16'h0005);
    run(LAC, 8'h04, 4'd4, 1'b0, 1'b0);
    run(ADD, 8'h06, 4'd0, 1'b0, 1'b0);
    run(SACH, 8'h10, 4'd4, 1'b0, 1'b0);
    chk("sach_acc", acc, 32'h0001_2345);
    chk("sach_mem", 32'(mem[8'h10]), 32'h0000_0012);

    // Back-to-back: SACH accepted in the LAC done cycle
    issue(LAC, 8'h05, 4'd4, 1'b0, 1'b0, a1);
    issue(SACH, 8'h11, 4'd4, 1'b0, 1'b0, a2);
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_accept", 32'(a2), 32'(a1 + 3));

    // Reset during EXEC of an ADD
    issue(ADD, 8'h05, 4'd3, 1'b0, 1'b0, a1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    ref_acc = '0; ref_ov = 1'b0;
    chk("rstx_acc", acc, 32'd0);
    chk("rstx_ready", 32'(cmd_ready), 32'd1);
    chk("rstx_done", 32'(done), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Randomized commands, valid held while busy, occasional gaps and clears
    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), 1'b0, a1);
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("final_acc", acc, ref_acc);
    chk("final_ov", 32'(ov), 32'(ref_ov));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
